// File: rtl/five_vote_ctrl.sv
// Five-voter majority controller: collects one vote per voter per round and
// decides once all five have voted or the round timer expires.
module five_vote_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] vote_vld,
    input  logic [4:0] vote_val,
    output logic [4:0] vote_ack,
    output logic       busy,
    output logic       result_vld,
    output logic       result,
    output logic       timeout_flag,
    output logic [4:0] missing
);

    // state   | meaning
    // IDLE    | waiting for start; votes ignored
    // COLLECT | accepting first vote from each voter, timer running
    // DECIDE  | one cycle; majority registered on exit
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] mask_q, mask_d;
    logic [4:0] val_q, val_d;
    logic [4:0] ack_q, ack_d;
    logic       tpend_q, tpend_d;
    logic       result_vld_q, result_vld_d;
    logic       result_q, result_d;
    logic       timeout_q, timeout_d;
    logic [4:0] missing_q, missing_d;

    logic [4:0] accept;
    logic [4:0] yes_votes;
    logic [2:0] yes_count;

    assign accept    = vote_vld & ~mask_q;
    // Unlatched voters count as 0.
    assign yes_votes = val_q & mask_q;
    assign yes_count = {2'b00, yes_votes[0]} + {2'b00, yes_votes[1]}
                     + {2'b00, yes_votes[2]} + {2'b00, yes_votes[3]}
                     + {2'b00, yes_votes[4]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        val_d        = val_q;
        ack_d        = 5'b00000;
        tpend_d      = tpend_q;
        result_vld_d = 1'b0;
        result_d     = result_q;
        timeout_d    = timeout_q;
        missing_d    = missing_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    cnt_d   = 8'd0;
                    mask_d  = 5'b00000;
                    val_d   = 5'b00000;
                    tpend_d = 1'b0;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    mask_d = mask_q | accept;
                    val_d  = (val_q & ~accept) | (vote_val & accept);
                    ack_d  = accept;
                    cnt_d  = cnt_q + 8'd1;
                    // Completion beats timeout when both happen on one edge.
                    if ((mask_q | accept) == 5'b11111) begin
                        state_d = DECIDE;
                        tpend_d = 1'b0;
                    end else if (cnt_q == CNT_TC) begin
                        state_d = DECIDE;
                        tpend_d = 1'b1;
                    end
                end
            end
            DECIDE: begin
                state_d = IDLE;
                if (!abort) begin
                    result_vld_d = 1'b1;
                    result_d     = (yes_count >= 3'd3);
                    timeout_d    = tpend_q;
                    missing_d    = ~mask_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            mask_q       <= 5'b00000;
            val_q        <= 5'b00000;
            ack_q        <= 5'b00000;
            tpend_q      <= 1'b0;
            result_vld_q <= 1'b0;
            result_q     <= 1'b0;
            timeout_q    <= 1'b0;
            missing_q    <= 5'b00000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            val_q        <= val_d;
            ack_q        <= ack_d;
            tpend_q      <= tpend_d;
            result_vld_q <= result_vld_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            missing_q    <= missing_d;
        end
    end

    assign vote_ack     = ack_q;
    assign busy         = (state_q == COLLECT) || (state_q == DECIDE);
    assign result_vld   = result_vld_q;
    assign result       = result_q;
    assign timeout_flag = timeout_q;
    assign missing      = missing_q;

endmodule

// File: tb/tb_five_vote_ctrl.sv
// Directed bench for five_vote_ctrl: a vector table for single-cycle-checkable
// rounds plus hand sequences for timeout, late fifth vote and async reset.
module tb_five_vote_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [4:0] vote_vld;
    logic [4:0] vote_val;
    logic [4:0] vote_ack;
    logic       busy;
    logic       result_vld;
    logic       result;
    logic       timeout_flag;
    logic [4:0] missing;

    int n_vec = 0;
    int n_err = 0;

    five_vote_ctrl #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .vote_vld     (vote_vld),
        .vote_val     (vote_val),
        .vote_ack     (vote_ack),
        .busy         (busy),
        .result_vld   (result_vld),
        .result       (result),
        .timeout_flag (timeout_flag),
        .missing      (missing)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       s;
        logic       a;
        logic [4:0] vld;
        logic [4:0] val;
        logic [4:0] ack;
        logic       bsy;
        logic       rvld;
        logic       res;
        logic       tf;
        logic [4:0] miss;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic s, input logic a,
                       input logic [4:0] vld, input logic [4:0] val,
                       input logic [4:0] ack, input logic bsy, input logic rvld,
                       input logic res, input logic tf, input logic [4:0] miss);
        vec_t v;
        v.name = name; v.s = s; v.a = a; v.vld = vld; v.val = val;
        v.ack = ack; v.bsy = bsy; v.rvld = rvld; v.res = res; v.tf = tf;
        v.miss = miss;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [4:0] ack, input logic bsy,
                       input logic rvld, input logic res, input logic tf,
                       input logic [4:0] miss);
        n_vec++;
        if ({vote_ack, busy, result_vld, result, timeout_flag, missing} !==
            {ack, bsy, rvld, res, tf, miss}) begin
            n_err++;
            $display("FAIL %s: got ack=%b busy=%b rvld=%b res=%b tf=%b miss=%b, want ack=%b busy=%b rvld=%b res=%b tf=%b miss=%b",
                     name, vote_ack, busy, result_vld, result, timeout_flag, missing,
                     ack, bsy, rvld, res, tf, miss);
        end
    endtask

    // Drive inputs, take one rising edge, settle just after it.
    task automatic step(input logic s, input logic a, input logic [4:0] vld,
                        input logic [4:0] val);
        start = s; abort = a; vote_vld = vld; vote_val = val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        vote_vld = 5'b0; vote_val = 5'b0;

        //   name          s  a  vld       val       ack       bsy rvld res tf miss
        // Round with votes 1,0,0,1,0 one per cycle; voter 2 retries with a 1.
        add("r1_start",    1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000);
        add("r1_v0",       0, 0, 5'b00001, 5'b00001, 5'b00001, 1, 0, 0, 0, 5'b00000);
        add("r1_v1",       0, 0, 5'b00010, 5'b00000, 5'b00010, 1, 0, 0, 0, 5'b00000);
        add("r1_v2",       0, 0, 5'b00100, 5'b00000, 5'b00100, 1, 0, 0, 0, 5'b00000);
        add("r1_v2_again", 0, 0, 5'b00100, 5'b00100, 5'b00000, 1, 0, 0, 0, 5'b00000);
        add("r1_v3",       0, 0, 5'b01000, 5'b01000, 5'b01000, 1, 0, 0, 0, 5'b00000);
        add("r1_v4",       0, 0, 5'b10000, 5'b00000, 5'b10000, 1, 0, 0, 0, 5'b00000);
        add("r1_result",   0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 0, 5'b00000);
        add("idle_vld",    0, 0, 5'b11111, 5'b11111, 5'b00000, 0, 0, 0, 0, 5'b00000);
        // All five on one edge, values 10110 -> three ones.
        add("r2_start",    1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000);
        add("r2_all",      0, 0, 5'b11111, 5'b10110, 5'b11111, 1, 0, 0, 0, 5'b00000);
        add("r2_decide",   0, 0, 5'b11111, 5'b00000, 5'b00000, 0, 1, 1, 0, 5'b00000);
        add("r2_hold",     0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 1, 0, 5'b00000);
        // Abort after two votes; result 1 must be held.
        add("r3_start",    1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 1, 0, 5'b00000);
        add("r3_two",      0, 0, 5'b00011, 5'b00011, 5'b00011, 1, 0, 1, 0, 5'b00000);
        add("r3_abort",    0, 1, 5'b00100, 5'b00100, 5'b00000, 0, 0, 1, 0, 5'b00000);
        add("r3_after",    0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 1, 0, 5'b00000);
        add("r4_start",    1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 1, 0, 5'b00000);
        add("r4_all",      0, 0, 5'b11111, 5'b00000, 5'b11111, 1, 0, 1, 0, 5'b00000);
        add("r4_result",   0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 0, 5'b00000);
        // Start during the result pulse is honoured; start while busy ignored;
        // abort in DECIDE suppresses the result.
        add("r5_start",    1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000);
        add("r5_all",      1, 0, 5'b11111, 5'b11111, 5'b11111, 1, 0, 0, 0, 5'b00000);
        add("r5_abort_dec",0, 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'b00000);
        add("r5_quiet",    0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'b00000);

        #12;
        chk("reset_state", 5'b00000, 0, 0, 0, 0, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].a, tbl[i].vld, tbl[i].val);
            chk(tbl[i].name, tbl[i].ack, tbl[i].bsy, tbl[i].rvld, tbl[i].res,
                tbl[i].tf, tbl[i].miss);
        end

        // Timeout: voters 0..2 vote 1 on the first COLLECT edge, then silence.
        step(1, 0, 5'b00000, 5'b00000);
        step(0, 0, 5'b00111, 5'b00111);
        chk("to_votes", 5'b00111, 1, 0, 0, 0, 5'b00000);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 5'b00000, 5'b00000);
            chk("to_wait", 5'b00000, 1, 0, 0, 0, 5'b00000);
        end
        step(0, 0, 5'b00000, 5'b00000);
        chk("to_result", 5'b00000, 0, 1, 1, 1, 5'b11000);
        step(0, 0, 5'b00000, 5'b00000);
        chk("to_hold", 5'b00000, 0, 0, 1, 1, 5'b11000);

        // Fifth vote lands on the timeout edge: completion wins.
        step(1, 0, 5'b00000, 5'b00000);
        step(0, 0, 5'b01111, 5'b01111);
        for (int i = 0; i < 14; i++) step(0, 0, 5'b00000, 5'b00000);
        step(0, 0, 5'b10000, 5'b10000);
        chk("late5_ack", 5'b10000, 1, 0, 1, 1, 5'b11000);
        step(0, 0, 5'b00000, 5'b00000);
        chk("late5_result", 5'b00000, 0, 1, 1, 0, 5'b00000);

        // Async reset mid-COLLECT while an ack is showing.
        step(1, 0, 5'b00000, 5'b00000);
        step(0, 0, 5'b00011, 5'b00011);
        chk("pre_reset", 5'b00011, 1, 0, 1, 0, 5'b00000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 5'b00000, 0, 0, 0, 0, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 5'b11111, 5'b11111);
        chk("post_reset_vld", 5'b00000, 0, 0, 0, 0, 5'b00000);
        step(0, 0, 5'b11111, 5'b11111);
        step(0, 0, 5'b00000, 5'b00000);
        chk("post_reset_quiet", 5'b00000, 0, 0, 0, 0, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, want finish before 100000");
        $fatal(1);
    end

endmodule
